// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by the FSM/arbiter top and by the storage array.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;
    localparam int CNT_W      = 3;

    localparam logic [WORD_W-1:0] ZERO_DATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // An access is legal only when word aligned and inside the 2^aw word window.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] upper;
        upper = addr >> (aw + BYTE_OFF_W);
        return (addr[BYTE_OFF_W-1:0] == '0) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Target end of the core's data-memory interface: write-priority arbitration,
// fixed-latency reads and a sticky illegal-access flag.
//
// Handshake: a requester raises req with address (and data) stable and keeps
// them held until the matching ack; ack is combinational and the transfer
// happens on the rising edge that ends the ack cycle. Requests are accepted
// only in IDLE; a write wins over a simultaneous read, which stays pending.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ill_q, ill_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_legal;
    logic              wr_legal;
    logic              idle;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              resp_ill;
    logic [WORD_W-1:0] resp_data;

    assign rd_idx   = rd_addr[ADDR_W+1:BYTE_OFF_W];
    assign wr_idx   = wr_addr[ADDR_W+1:BYTE_OFF_W];
    assign rd_legal = addr_legal(rd_addr, ADDR_W);
    assign wr_legal = addr_legal(wr_addr, ADDR_W);

    // Acks are suppressed while reset is asserted, not only after it.
    assign idle   = (state_q == ST_IDLE) && n_reset;
    assign wr_ack = idle & wr_req;
    assign rd_ack = idle & rd_req & ~wr_req;
    assign mem_we = wr_ack & wr_legal;

    // One array port: writes use it in IDLE; the read is sampled when entering
    // RESP, from the incoming index (LATENCY==1) or the latched one.
    always_comb begin
        if (wr_ack) begin
            mem_addr = wr_idx;
        end else if (state_q == ST_IDLE) begin
            mem_addr = rd_idx;
        end else begin
            mem_addr = idx_q;
        end
    end

    assign resp_ill  = (state_q == ST_IDLE) ? ~rd_legal : ill_q;
    assign resp_data = resp_ill ? ZERO_DATA : mem_rdata;

    mem_array #(
        .ADDR_W(ADDR_W)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wr_data),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ill_d      = ill_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = err_q | (wr_ack & ~wr_legal) | (rd_ack & ~rd_legal);

        case (state_q)
            ST_IDLE: begin
                if (rd_ack) begin
                    idx_d = rd_idx;
                    ill_d = ~rd_legal;
                    cnt_d = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        rd_valid_d = 1'b1;
                        rd_data_d  = resp_data;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // The counter reaches 0 on the same edge that enters RESP.
                if (cnt_q <= 1) begin
                    cnt_d      = '0;
                    state_d    = ST_RESP;
                    rd_valid_d = 1'b1;
                    rd_data_d  = resp_data;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            ill_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ill_q      <= ill_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instances at LATENCY 2 (main), 1 and 4.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        rd_req   [3];
    logic [31:0] rd_addr  [3];
    logic        rd_ack   [3];
    logic        rd_valid [3];
    logic [31:0] rd_data  [3];
    logic        wr_req   [3];
    logic [31:0] wr_addr  [3];
    logic [31:0] wr_data  [3];
    logic        wr_ack   [3];
    logic        err      [3];
    logic [1:0]  dbg_state[3];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        mem_responder #(
            .ADDR_W (10),
            .LATENCY(LAT)
        ) u_dut (
            .clk      (clk),
            .n_reset  (n_reset),
            .rd_req   (rd_req[g]),
            .rd_addr  (rd_addr[g]),
            .rd_ack   (rd_ack[g]),
            .rd_valid (rd_valid[g]),
            .rd_data  (rd_data[g]),
            .wr_req   (wr_req[g]),
            .wr_addr  (wr_addr[g]),
            .wr_data  (wr_data[g]),
            .wr_ack   (wr_ack[g]),
            .err      (err[g]),
            .dbg_state(dbg_state[g])
        );
    end

    // ---------------- driver tasks ----------------
    task automatic read_txn(input int k, input logic [31:0] addr,
                            output int ack_c, output int val_c, output logic [31:0] data);
        ack_c = -1;
        val_c = -1;
        data  = 'x;
        @(negedge clk);
        rd_req[k]  = 1'b1;
        rd_addr[k] = addr;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rd_ack[k] === 1'b1) begin
                ack_c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ack_c < 0) begin
            rd_req[k] = 1'b0;
            return;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rd_req[k] = 1'b0;
            #1;
            if (rd_valid[k] === 1'b1) begin
                val_c = cyc;
                data  = rd_data[k];
                break;
            end
        end
        rd_req[k] = 1'b0;
    endtask

    task automatic write_txn(input int k, input logic [31:0] addr, input logic [31:0] data,
                             output logic acked);
        @(negedge clk);
        wr_req[k]  = 1'b1;
        wr_addr[k] = addr;
        wr_data[k] = data;
        #1;
        acked = wr_ack[k];
        @(posedge clk);
        #1;
        wr_req[k] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_reset   = 1'b0;
        wr_req[0] = 1'b1;
        rd_req[0] = 1'b1;
        wr_addr[0] = 32'h0;
        rd_addr[0] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (wr_ack[0] !== 1'b0) begin errors++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack[0]); end
        checks++;
        if (rd_ack[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack[0]); end
        checks++;
        if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid[0]); end
        checks++;
        if (rd_data[0] !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data[0]); end
        checks++;
        if (err[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err[0]); end
        checks++;
        if (dbg_state[0] !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state[0]); end
        wr_req[0] = 1'b0;
        rd_req[0] = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_write_then_read();
        int tw;
        @(negedge clk);
        wr_req[0]  = 1'b1;
        wr_addr[0] = 32'h0000_0010;
        wr_data[0] = 32'hDEAD_BEEF;
        #1;
        tw = cyc;
        checks++;
        if (wr_ack[0] !== 1'b1) begin errors++; $display("FAIL wtr_wr_ack: got %b want 1", wr_ack[0]); end
        @(negedge clk);
        wr_req[0]  = 1'b0;
        rd_req[0]  = 1'b1;
        rd_addr[0] = 32'h0000_0010;
        #1;
        checks++;
        if (rd_ack[0] !== 1'b1 || cyc !== tw + 1)
            begin errors++; $display("FAIL wtr_rd_ack: got ack=%b cyc=%0d want ack=1 cyc=%0d", rd_ack[0], cyc, tw + 1); end
        @(negedge clk);
        rd_req[0] = 1'b0;
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL wtr_early_valid: got %b want 0", rd_valid[0]); end
        @(negedge clk);
        #1;
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'hDEAD_BEEF || cyc !== tw + 3)
            begin errors++; $display("FAIL wtr_rd_valid: got v=%b d=%h cyc=%0d want v=1 d=deadbeef cyc=%0d", rd_valid[0], rd_data[0], cyc, tw + 3); end
        @(negedge clk);
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL wtr_hold: got v=%b d=%h want v=0 d=deadbeef", rd_valid[0], rd_data[0]); end
    endtask

    task automatic test_simultaneous();
        int ack_c;
        int val_c;
        @(negedge clk);
        wr_req[0]  = 1'b1;
        wr_addr[0] = 32'h0000_0020;
        wr_data[0] = 32'h1234_5678;
        rd_req[0]  = 1'b1;
        rd_addr[0] = 32'h0000_0020;
        #1;
        checks++;
        if (wr_ack[0] !== 1'b1 || rd_ack[0] !== 1'b0)
            begin errors++; $display("FAIL sim_arb: got wr_ack=%b rd_ack=%b want 1 0", wr_ack[0], rd_ack[0]); end
        @(negedge clk);
        wr_req[0] = 1'b0;
        #1;
        ack_c = cyc;
        checks++;
        if (rd_ack[0] !== 1'b1) begin errors++; $display("FAIL sim_rd_ack: got %b want 1", rd_ack[0]); end
        val_c = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rd_req[0] = 1'b0;
            #1;
            if (rd_valid[0] === 1'b1) begin
                val_c = cyc;
                break;
            end
        end
        checks++;
        if (val_c - ack_c !== 2 || rd_data[0] !== 32'h1234_5678)
            begin errors++; $display("FAIL sim_rd_data: got lat=%0d d=%h want lat=2 d=12345678", val_c - ack_c, rd_data[0]); end
    endtask

    task automatic test_illegal();
        int          ack_c;
        int          val_c;
        logic [31:0] d;
        logic        ok;
        checks++;
        if (err[0] !== 1'b0) begin errors++; $display("FAIL ill_err_pre: got %b want 0", err[0]); end
        write_txn(0, 32'h0000_0000, 32'h1111_1111, ok);
        read_txn(0, 32'h0000_0003, ack_c, val_c, d);
        checks++;
        if (ack_c < 0 || val_c - ack_c !== 2 || d !== 32'h0)
            begin errors++; $display("FAIL ill_read: got ack=%0d lat=%0d d=%h want lat=2 d=0", ack_c, val_c - ack_c, d); end
        checks++;
        if (err[0] !== 1'b1) begin errors++; $display("FAIL ill_err_set: got %b want 1", err[0]); end
        write_txn(0, 32'h0000_1000, 32'hCAFE_F00D, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ill_wr_ack: got %b want 1", ok); end
        read_txn(0, 32'h0000_0000, ack_c, val_c, d);
        checks++;
        if (d !== 32'h1111_1111) begin errors++; $display("FAIL ill_mem_unchanged: got %h want 11111111", d); end
        checks++;
        if (err[0] !== 1'b1) begin errors++; $display("FAIL ill_err_sticky: got %b want 1", err[0]); end
    endtask

    task automatic test_reset_mid_read();
        int          ack_c;
        int          val_c;
        logic [31:0] d;
        logic        seen;
        @(negedge clk);
        rd_req[0]  = 1'b1;
        rd_addr[0] = 32'h0000_0010;
        #1;
        checks++;
        if (rd_ack[0] !== 1'b1) begin errors++; $display("FAIL rmr_ack: got %b want 1", rd_ack[0]); end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_state[0] !== 2'd1) begin errors++; $display("FAIL rmr_wait_state: got %0d want 1", dbg_state[0]); end
        n_reset = 1'b0;
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h0 || err[0] !== 1'b0 || dbg_state[0] !== 2'd0 || rd_ack[0] !== 1'b0)
            begin errors++; $display("FAIL rmr_reset_vals: got v=%b d=%h err=%b st=%0d ack=%b want all 0",
                                     rd_valid[0], rd_data[0], err[0], dbg_state[0], rd_ack[0]); end
        @(negedge clk);
        rd_req[0] = 1'b0;
        n_reset   = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #1;
            if (rd_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmr_no_valid: got stray rd_valid=1 want none"); end
        read_txn(0, 32'h0000_0010, ack_c, val_c, d);
        checks++;
        if (ack_c < 0 || val_c - ack_c !== 2 || d !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL rmr_next_read: got ack=%0d lat=%0d d=%h want lat=2 d=deadbeef", ack_c, val_c - ack_c, d); end
    endtask

    task automatic test_back_to_back();
        int          ack_c;
        int          val_c;
        int          start;
        logic [31:0] d;
        logic [31:0] exp_d;
        @(negedge clk);
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            wr_req[0]  = 1'b1;
            wr_addr[0] = 32'(i * 4);
            wr_data[0] = 32'hA500_0000 + 32'(i * 32'h111);
            #1;
            checks++;
            if (wr_ack[0] !== 1'b1 || cyc !== start + i)
                begin errors++; $display("FAIL b2b_wr_ack[%0d]: got ack=%b cyc=%0d want ack=1 cyc=%0d", i, wr_ack[0], cyc, start + i); end
            @(negedge clk);
        end
        wr_req[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_d = 32'hA500_0000 + 32'(i * 32'h111);
            read_txn(0, 32'(i * 4), ack_c, val_c, d);
            checks++;
            if (ack_c < 0 || val_c - ack_c !== 2 || d !== exp_d)
                begin errors++; $display("FAIL b2b_rd[%0d]: got ack=%0d lat=%0d d=%h want lat=2 d=%h", i, ack_c, val_c - ack_c, d, exp_d); end
        end
    endtask

    task automatic test_latency_sweep(input int k, input int lat);
        int   acks[$];
        int   vals[$];
        logic ok;
        write_txn(k, 32'h0000_0008, 32'h0BAD_F00D, ok);
        @(negedge clk);
        rd_req[k]  = 1'b1;
        rd_addr[k] = 32'h0000_0008;
        for (int n = 0; n < 3 * (lat + 1) + lat + 2; n++) begin
            if (n == 3 * (lat + 1)) rd_req[k] = 1'b0;
            #1;
            if (rd_ack[k] === 1'b1) acks.push_back(cyc);
            if (rd_valid[k] === 1'b1) begin
                vals.push_back(cyc);
                checks++;
                if (rd_data[k] !== 32'h0BAD_F00D)
                    begin errors++; $display("FAIL sweep_l%0d_data: got %h want 0badf00d", lat, rd_data[k]); end
            end
            @(negedge clk);
        end
        rd_req[k] = 1'b0;
        checks++;
        if (acks.size() !== 3 || vals.size() !== 3)
            begin errors++; $display("FAIL sweep_l%0d_count: got acks=%0d valids=%0d want 3 3", lat, acks.size(), vals.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vals[i] - acks[i] !== lat)
                    begin errors++; $display("FAIL sweep_l%0d_lat[%0d]: got %0d want %0d", lat, i, vals[i] - acks[i], lat); end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (acks[i + 1] - acks[i] !== lat + 1)
                    begin errors++; $display("FAIL sweep_l%0d_spacing[%0d]: got %0d want %0d", lat, i, acks[i + 1] - acks[i], lat + 1); end
            end
        end
    endtask

    initial begin
        n_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_req[k]  = 1'b0;
            rd_addr[k] = '0;
            wr_req[k]  = 1'b0;
            wr_addr[k] = '0;
            wr_data[k] = '0;
        end
        test_reset();
        test_write_then_read();
        test_simultaneous();
        test_illegal();
        test_reset_mid_read();
        test_back_to_back();
        test_latency_sweep(1, 1);
        test_latency_sweep(2, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors + 1, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the Lua processor core: the target end of the memory interface driven by the fetch stage (reads) and the memory write-back stage (writes). It accepts one request at a time over a req/ack handshake. It arbitrates between simultaneous reads and writes, and returns read data after a fixed, parameterised latency. It also flags illegal accesses.

## Interface
- `ADDR_W`, default 10: word-address width; the memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: read latency in cycles, from accept to `rd_valid`; legal range 1..4.
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `rd_req`, in, 1: read request; held with `rd_addr` until `rd_ack`.
- `rd_addr`, in, 32: byte address of the read.
- `rd_ack`, out, 1: read accepted this cycle; combinational.
- `rd_valid`, out, 1: `rd_data` is valid; one-cycle pulse.
- `rd_data`, out, 32: read result.
- `wr_req`, in, 1: write request; held with `wr_addr`/`wr_data` until `wr_ack`.
- `wr_addr`, in, 32: byte address of the write.
- `wr_data`, in, 32: write data.
- `wr_ack`, out, 1: write accepted and committed this cycle; combinational.
- `err`, out, 1: sticky illegal-access flag.

## Operation
- FSM states:
  - **IDLE**: the only state that accepts requests.
  - **WAIT**: counting down the read latency.
  - **RESP**: driving `rd_valid`.
- Arbitration in IDLE:
  - `wr_req` has priority over `rd_req`, so write-back data is visible to a following read.
  - `wr_ack = (state==IDLE) & wr_req`.
  - `rd_ack = (state==IDLE) & rd_req & ~wr_req`.
- Write:
  - Committed on the clock edge of the cycle in which `wr_ack=1`.
  - State stays IDLE, so back-to-back writes run at one per cycle.
- Read:
  - On `rd_ack`, latch the word index and load the latency counter with `LATENCY-1`.
  - `LATENCY==1` goes directly to RESP; otherwise go to WAIT.
  - WAIT decrements the counter each cycle and moves to RESP when it reaches 0.
  - RESP asserts `rd_valid` for exactly one cycle with the word read from the latched index, then returns to IDLE.
  - No request is accepted in WAIT or RESP.
- Addressing:
  - Word index = `addr[ADDR_W+1:2]`.
  - An access is illegal if `addr[1:0]!=0` or `addr[31:ADDR_W+2]!=0`.
- Illegal write: acked normally, memory unchanged, `err` set.
- Illegal read: acked normally, `rd_valid` at normal latency with `rd_data=32'h0000_0000`, `err` set.
- `err` stays set until reset.
- `rd_data` holds its last value when `rd_valid=0`.
- Counter is 3 bits wide. The counter and FSM never wrap: RESP always returns to IDLE.

## Timing
- Reset values: state IDLE, counter 0, `rd_valid=0`, `rd_data=0`, `err=0`. `rd_ack` and `wr_ack` are 0 during reset. Memory contents are not reset.
- Read accepted at cycle t: `rd_valid=1` at t+LATENCY only. The earliest next accept is t+LATENCY+1, so sustained read throughput is one per LATENCY+1 cycles.
- Write accepted at cycle t: a read accepted at t+1 returns the new data.
- `rd_req` and `wr_req` both high in IDLE: the write is acked at t. The read stays pending and is acked at t+1, provided `wr_req` has dropped.
- Requests arriving during WAIT/RESP are ignored until IDLE, and must remain held by the requester.
- Reset asserted mid-read: the pending response is discarded and no `rd_valid` occurs after reset release.
- Requester must not change address or data while req=1 and ack=0.

## Structure
- Shared package/header `mem_pkg`:
  - FSM state encoding (IDLE/WAIT/RESP).
  - Word-size constant (32).
  - Zero-data constant for illegal reads.
  - Byte-offset width (2).
- One natural sub-module `mem_array`: a 2^ADDR_W×32 single-port array with synchronous write and asynchronous read, with no reset on contents.
- FSM, counter, arbitration, and legality checks live in `mem_responder`.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, then read 0x10 with LATENCY=2: `wr_ack` at t, `rd_ack` at t+1, `rd_valid` with 0xDEAD_BEEF at t+3.
- `rd_req` and `wr_req` raised together at the same address 0x20 with data 0x1234_5678: write acked first, read acked next cycle, returns 0x1234_5678.
- Misaligned read 0x0000_0003: acked, `rd_valid` with 0x0 at normal latency, `err=1` and stays 1. Out-of-range write 0x0000_1000 (ADDR_W=10): acked, memory unchanged.
- Read acked, then `n_reset` pulsed low in WAIT: outputs return to reset values, no `rd_valid` afterwards, and the next read completes normally.
- Sweep LATENCY=1 and LATENCY=4 with back-to-back held reads: `rd_valid` exactly LATENCY cycles after each ack, with acks spaced LATENCY+1 cycles.
- Burst of 8 consecutive writes, one per cycle, to words 0..7, then read all 8: each returns its written value; `wr_ack` is high on all 8 consecutive cycles.
